// File: rtl/hazard_ctrl.sv
// Stall/halt controller for an in-order core without operand forwarding.
// A shift-register scoreboard of in-flight destinations drives bbl; stop drains then halts.
module hazard_ctrl #(
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exp_read1,
  input  logic [4:0]  exp_addr1,
  input  logic        exp_read2,
  input  logic [4:0]  exp_addr2,
  input  logic [4:0]  tar_addr,
  input  logic        stop,
  output logic        bbl,
  output logic        halted,
  output logic [31:0] stall_cnt
);
  localparam int CHECK = DEPTH - WB_BYPASS;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [DEPTH-1:0]      slot_vld;
  logic [DEPTH-1:0][4:0] slot_addr;
  logic [1:0]            state;
  logic [2:0]            drain_cnt;
  logic [31:0]           stall_q;
  logic                  hazard;

  // The oldest slot is skipped when the regfile forwards same-cycle writes.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < CHECK && slot_vld[i] &&
          ((exp_read1 && exp_addr1 == slot_addr[i]) ||
           (exp_read2 && exp_addr2 == slot_addr[i])))
        hazard = 1'b1;
    end
  end

  assign bbl       = !rst && (state != S_RUN || stop || hazard);
  assign halted    = !rst && (state == S_HALT);
  assign stall_cnt = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld  <= '0;
      slot_addr <= '0;
      state     <= S_RUN;
      drain_cnt <= 3'd0;
      stall_q   <= 32'd0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        slot_vld[i]  <= slot_vld[i-1];
        slot_addr[i] <= slot_addr[i-1];
      end
      // r0 never enters, so reads of $0 can never stall.
      slot_vld[0]  <= !bbl && tar_addr != 5'd0;
      slot_addr[0] <= tar_addr;
      case (state)
        S_RUN: begin
          if (stop) begin
            state     <= S_DRAIN;
            drain_cnt <= 3'(DEPTH);
          end else if (hazard && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - 3'd1;
          if (drain_cnt == 3'd1) state <= S_HALT;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a bypassing (default) and a non-bypassing instance share
// stimulus; a history-of-issued-destinations model predicts both.
module tb_hazard_ctrl;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst, r1, r2, stp;
  logic [4:0] a1, a2, tar;
  logic ob[2], oh[2];
  logic [31:0] oc[2];

  int ntot = 0, nbad = 0;

  // model state: hist[d][k] = destination issued k+1 edges ago (0 = none)
  int hist[2][8];
  logic [31:0] mcnt[2];
  int since[2];
  logic haz[2], eb[2], eh[2];

  always #5 clk = ~clk;

  hazard_ctrl #(.DEPTH(D), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .exp_read1(r1), .exp_addr1(a1), .exp_read2(r2),
    .exp_addr2(a2), .tar_addr(tar), .stop(stp), .bbl(ob[0]), .halted(oh[0]),
    .stall_cnt(oc[0]));

  hazard_ctrl #(.DEPTH(D), .WB_BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .exp_read1(r1), .exp_addr1(a1), .exp_read2(r2),
    .exp_addr2(a2), .tar_addr(tar), .stop(stp), .bbl(ob[1]), .halted(oh[1]),
    .stall_cnt(oc[1]));

  task automatic idle();
    r1 = 0; r2 = 0; a1 = 0; a2 = 0; tar = 0; stp = 0;
  endtask

  task automatic predict();
    for (int d = 0; d < 2; d++) begin
      int chk;
      chk = D - ((d == 0) ? 1 : 0);
      haz[d] = 1'b0;
      for (int k = 0; k < chk; k++)
        if (hist[d][k] != 0 && ((r1 && int'(a1) == hist[d][k]) || (r2 && int'(a2) == hist[d][k])))
          haz[d] = 1'b1;
      eb[d] = !rst && (since[d] >= 0 || stp || haz[d]);
      eh[d] = !rst && since[d] > D;
    end
  endtask

  task automatic tick();
    predict();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) hist[d][k] = 0;
        mcnt[d] = 0;
        since[d] = -1;
      end else begin
        if (since[d] < 0 && !stp && haz[d] && mcnt[d] != 32'hFFFF_FFFF) mcnt[d] = mcnt[d] + 1;
        for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = (!eb[d] && tar != 0) ? int'(tar) : 0;
        if (since[d] >= 0) begin
          if (since[d] < 50) since[d]++;
        end else if (stp) since[d] = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1; stp = 1; r1 = 1; a1 = 5'd3;
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        ntot++;
        if (ob[d] !== 1'b0 || oh[d] !== 1'b0) begin
          nbad++; $display("FAIL reset_out d=%0d bbl=%b halted=%b want 0/0", d, ob[d], oh[d]);
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      ntot++;
      if (oc[d] !== 32'd0) begin nbad++; $display("FAIL reset_cnt d=%0d got=%h want 0", d, oc[d]); end
    end
    rst = 0; idle(); #1;
    for (int d = 0; d < 2; d++) begin
      ntot++;
      if (ob[d] !== 1'b0) begin nbad++; $display("FAIL post_reset_bbl d=%0d got=%b want 0", d, ob[d]); end
    end
    for (int c = 0; c < D; c++) tick();
  endtask

  // consumer right behind producer: 2 stalls with bypass, 3 without
  task automatic test_dist1();
    logic [31:0] c0[2];
    c0[0] = oc[0]; c0[1] = oc[1];
    idle(); tar = 5'd5; tick();
    tar = 0; r1 = 1; a1 = 5'd5;
    for (int c = 1; c <= 4; c++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        logic want;
        want = (c <= 2 + d);
        ntot++;
        if (ob[d] !== want) begin nbad++; $display("FAIL dist1_bbl d=%0d cyc=%0d got=%b want %b", d, c, ob[d], want); end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      ntot++;
      if (oc[d] - c0[d] !== 32'(2 + d)) begin
        nbad++; $display("FAIL dist1_cnt d=%0d got=%0d want %0d", d, oc[d] - c0[d], 2 + d);
      end
    end
    idle(); for (int c = 0; c < D; c++) tick();
  endtask

  task automatic test_dist2();
    logic [31:0] c0;
    c0 = oc[0];
    idle(); tar = 5'd7; tick();
    tar = 0; tick();
    r2 = 1; a2 = 5'd7;
    for (int c = 2; c <= 3; c++) begin
      #1; ntot++;
      if (ob[0] !== (c == 2)) begin nbad++; $display("FAIL dist2_bbl cyc=%0d got=%b want %b", c, ob[0], c == 2); end
      tick();
    end
    ntot++;
    if (oc[0] - c0 !== 32'd1) begin nbad++; $display("FAIL dist2_cnt got=%0d want 1", oc[0] - c0); end
    idle(); for (int c = 0; c < D; c++) tick();
  endtask

  task automatic test_no_false();
    idle(); tar = 5'd0; tick();
    r1 = 1; a1 = 5'd0; r2 = 1; a2 = 5'd0; #1; ntot++;
    if (ob[0] !== 1'b0 || ob[1] !== 1'b0) begin nbad++; $display("FAIL r0_read got=%b%b want 00", ob[0], ob[1]); end
    tick();
    idle(); tar = 5'd9; tick();
    tar = 0; r1 = 0; a1 = 5'd9; r2 = 1; a2 = 5'd8; #1; ntot++;
    if (ob[0] !== 1'b0 || ob[1] !== 1'b0) begin nbad++; $display("FAIL noread got=%b%b want 00", ob[0], ob[1]); end
    tick();
    idle(); for (int c = 0; c < D; c++) tick();
  endtask

  task automatic test_halt();
    idle(); stp = 1; #1; ntot++;
    if (ob[0] !== 1'b1 || oh[0] !== 1'b0) begin nbad++; $display("FAIL stop_cyc bbl=%b halted=%b want 1/0", ob[0], oh[0]); end
    tick(); stp = 0;
    for (int c = 1; c <= D + 3; c++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        ntot++;
        if (ob[d] !== 1'b1 || oh[d] !== (c > D)) begin
          nbad++; $display("FAIL halt_seq d=%0d cyc=%0d bbl=%b halted=%b want 1/%b", d, c, ob[d], oh[d], c > D);
        end
      end
      tick();
    end
    stp = 1; tick(); stp = 0; tick(); #1; ntot++;
    if (oh[0] !== 1'b1 || ob[0] !== 1'b1) begin nbad++; $display("FAIL second_stop halted=%b bbl=%b want 1/1", oh[0], ob[0]); end
    rst = 1; #1; ntot++;
    if (oh[0] !== 1'b0 || ob[0] !== 1'b0) begin nbad++; $display("FAIL halt_rst halted=%b bbl=%b want 0/0", oh[0], ob[0]); end
    tick(); rst = 0; #1; ntot++;
    if (oh[0] !== 1'b0 || ob[0] !== 1'b0 || oc[0] !== 32'd0) begin
      nbad++; $display("FAIL after_halt_rst halted=%b bbl=%b cnt=%0d want 0/0/0", oh[0], ob[0], oc[0]);
    end
    tick();
  endtask

  task automatic test_rst_mid_drain();
    idle(); stp = 1; tick(); stp = 0;
    tick();
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < D + 3; c++) begin
      #1; ntot++;
      if (oh[0] !== 1'b0 || ob[0] !== 1'b0) begin
        nbad++; $display("FAIL mid_drain_rst cyc=%0d halted=%b bbl=%b want 0/0", c, oh[0], ob[0]);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    idle();
    force dut.stall_q = 32'hFFFF_FFFE;
    force dut_nb.stall_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_q;
    release dut_nb.stall_q;
    mcnt[0] = 32'hFFFF_FFFE; mcnt[1] = 32'hFFFF_FFFE;
    @(negedge clk);
    tar = 5'd12; tick();
    tar = 0; r1 = 1; a1 = 5'd12;
    for (int c = 0; c < 4; c++) tick();
    for (int d = 0; d < 2; d++) begin
      ntot++;
      if (oc[d] !== 32'hFFFF_FFFF) begin nbad++; $display("FAIL saturate d=%0d got=%h want ffffffff", d, oc[d]); end
    end
    rst = 1; tick(); rst = 0; idle(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      r1 = 1'($urandom); r2 = 1'($urandom);
      a1 = 5'($urandom_range(0, 3)); a2 = 5'($urandom_range(0, 3));
      tar = 5'($urandom_range(0, 3));
      stp = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 79) == 0);
      #1; predict();
      for (int d = 0; d < 2; d++) begin
        ntot++;
        if (ob[d] !== eb[d] || oh[d] !== eh[d] || oc[d] !== mcnt[d]) begin
          nbad++;
          $display("FAIL rand d=%0d cyc=%0d bbl=%b halted=%b cnt=%0d want %b/%b/%0d",
                   d, c, ob[d], oh[d], oc[d], eb[d], eh[d], mcnt[d]);
        end
      end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) hist[d][k] = 0;
      mcnt[d] = 0; since[d] = -1;
    end
    idle(); rst = 1;
    @(negedge clk);
    test_reset();
    test_dist1();
    test_dist2();
    test_no_false();
    test_halt();
    test_rst_mid_drain();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule
